// File: rtl/param_register_file_if.sv
// Register-file bus: two read ports, one write port, PC alias input,
// clear request and live R0/R1/busy status outputs.
interface param_register_file_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             WE3;
  logic [AW-1:0]    A1;
  logic [AW-1:0]    A2;
  logic [AW-1:0]    A3;
  logic [WIDTH-1:0] WD3;
  logic [WIDTH-1:0] R15;
  logic             clear_req;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic [WIDTH-1:0] R0;
  logic [WIDTH-1:0] R1;
  logic             busy;

  modport master (
    output WE3, A1, A2, A3, WD3, R15, clear_req,
    input  RD1, RD2, R0, R1, busy
  );

  modport slave (
    input  WE3, A1, A2, A3, WD3, R15, clear_req,
    output RD1, RD2, R0, R1, busy
  );
endinterface

// File: rtl/param_register_file.sv
// Parameterised 2R1W register file with PC alias, optional write
// forwarding and a DEPTH-cycle sequential clear.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module param_register_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int PC_IDX = DEPTH - 1,
  parameter int BYPASS = 1
) (
  input logic                 clk,
  input logic                 rst,
  param_register_file_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] PC_A  = AW'(PC_IDX);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam bit            BYP   = (BYPASS != 0);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             busy;
  logic             wr_en;
  logic             clr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        // ptr wraps to 0 on the final clear edge
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy   = (state_q == CLEAR);
    clr_en = (state_q == CLEAR);
    wr_en  = bus.WE3 && !busy && (bus.A3 != PC_A);
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[bus.A3] = bus.WD3;
    end
    if (clr_en) begin
      mem_d[ptr_q] = '0;
    end
    // PC slot holds a constant so synthesis drops its flops
    mem_d[PC_IDX] = '0;
  end

  always_comb begin
    if (bus.A1 == PC_A) begin
      bus.RD1 = bus.R15;
    end else if (BYP && wr_en && (bus.A3 == bus.A1)) begin
      bus.RD1 = bus.WD3;
    end else begin
      bus.RD1 = mem_q[bus.A1];
    end

    if (bus.A2 == PC_A) begin
      bus.RD2 = bus.R15;
    end else if (BYP && wr_en && (bus.A3 == bus.A2)) begin
      bus.RD2 = bus.WD3;
    end else begin
      bus.RD2 = mem_q[bus.A2];
    end
  end

  assign bus.R0   = mem_q[0];
  assign bus.R1   = mem_q[1];
  assign bus.busy = busy;

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and data port.
REQ-002 Parameter DEPTH, default 16: number of register locations; must be a power of two, at least 4.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 Parameter PC_IDX, default DEPTH-1: index of the program-counter alias.
REQ-005 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-006 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 WE3  input  1  write enable for write port 3.
REQ-009 A1  input  AW  read address, port 1.
REQ-010 A2  input  AW  read address, port 2.
REQ-011 A3  input  AW  write address.
REQ-012 WD3  input  WIDTH  write data.
REQ-013 R15  input  WIDTH  external PC value, returned on reads of PC_IDX.
REQ-014 clear_req  input  1  one-cycle pulse that starts a sequential clear of all registers.
REQ-015 RD1  output  WIDTH  read data, port 1 (combinational).
REQ-016 RD2  output  WIDTH  read data, port 2 (combinational).
REQ-017 R0  output  WIDTH  live contents of register 0.
REQ-018 R1  output  WIDTH  live contents of register 1.
REQ-019 busy  output  1  high while the clear sequence runs.

Function
REQ-020 Storage: DEPTH x WIDTH flops; the PC_IDX location is never stored and never written.
REQ-021 Write: on a rising edge with WE3=1, busy=0, rst=0 and A3!=PC_IDX, reg[A3] <= WD3.
REQ-022 Read: RDn = R15 when An==PC_IDX; otherwise RDn = reg[An]. Zero-latency combinational path.
REQ-023 Bypass: when BYPASS=1, WE3=1, busy=0, A3==An and An!=PC_IDX, RDn = WD3 in the same cycle.
REQ-024 With BYPASS=0, a written value appears on RDn in the cycle after the write edge.
REQ-025 R0 and R1 always reflect stored reg[0] and reg[1]; bypass is never applied to them.
REQ-026 FSM states:
  - IDLE -> CLEAR on clear_req=1; ptr <= 0.
  - CLEAR: each cycle reg[ptr] <= 0 and ptr <= ptr+1.
  - CLEAR -> IDLE on the edge that clears ptr==DEPTH-1.
REQ-027 A clear therefore takes exactly DEPTH cycles; busy=1 for exactly those DEPTH cycles.
REQ-028 In CLEAR, WE3 is ignored (no write, no bypass); reads return the current array contents.
REQ-029 clear_req while busy=1 is ignored; the sequence does not restart.
REQ-030 The ptr counter is AW bits wide and wraps to 0 when the sequence exits.
REQ-031 If WE3 and clear_req are both high in IDLE, the write completes on that edge and CLEAR begins on the next cycle.

Reset
REQ-032 On a rising edge with rst=1, all stored registers, ptr and busy are set to 0 and the FSM goes to IDLE. This completes in one cycle and does not run the sequential clear.
REQ-033 rst has priority over WE3, clear_req and an in-progress CLEAR; asserting it mid-CLEAR aborts the sequence immediately.
REQ-034 After reset: R0=0, R1=0, busy=0; RD1/RD2 read 0 for any address except PC_IDX, which reads R15.

Verification
REQ-035 Reset, then A1=0, A2=1, R15=0x1234 -> RD1=0, RD2=0, R0=0, R1=0, busy=0; A1=15 -> RD1=0x1234.
REQ-036 WE3=1, A3=2, WD3=100, A1=2, BYPASS=1 -> RD1=100 before the edge; after the edge, with WE3=0, RD1=100.
REQ-037 WE3=1, A3=0, WD3=256 -> R0=256 after one edge; WE3=1, A3=15, WD3=7 -> no state change, RD1 at A1=15 still equals R15.
REQ-038 Fill reg[0..14] with nonzero values, pulse clear_req -> busy=1 for 16 cycles, then all registers read 0; WE3=1 during busy -> no write; a second clear_req mid-sequence -> sequence length unchanged.
REQ-039 Start a clear, assert rst at cycle 5 -> busy=0 and all registers 0 on the next cycle; a subsequent write to A3=3 with WD3=0xFF succeeds.
REQ-040 BYPASS=0 build: WE3=1, A3=4, WD3=9, A1=4 -> RD1 shows the old value that cycle and 9 the next cycle.
